// File: rtl/sram_bus_fabric.sv
// CPU-side SRAM-bus fabric: divided CPU clock and gate phase, slave window decode with
// read-data/wait mux, per-access wait timeout, and gate-phase interrupt synchronisation.
module sram_bus_fabric #(
  parameter int unsigned     NSLAVE       = 4,
  parameter int unsigned     SEL_LSB      = 10,
  parameter int unsigned     CLK_DIV      = 4,
  parameter int unsigned     GATE_PHASE   = 0,
  parameter int unsigned     WAIT_TIMEOUT = 255,
  parameter int unsigned     NIRQ         = 2,
  parameter logic [NIRQ-1:0] IRQ_EDGE     = '0
) (
  input  logic                  clk,
  input  logic                  nrst,
  output logic                  cpu_clk,
  output logic                  gate,
  input  logic                  sram_cs,
  input  logic [15:0]           sram_a,
  output logic [7:0]            sram_d_in,
  output logic                  sram_wait,
  output logic [NSLAVE-1:0]     s_cs,
  input  logic [8*NSLAVE-1:0]   s_d,
  input  logic [NSLAVE-1:0]     s_wait,
  input  logic [NIRQ-1:0]       irq_in,
  input  logic [NIRQ-1:0]       irq_ack,
  output logic [NIRQ-1:0]       irq_out,
  output logic                  timeout_flag,
  output logic [2:0]            timeout_slave,
  input  logic                  timeout_clr
);

  localparam int unsigned SW   = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int unsigned PW   = $clog2(CLK_DIV);
  localparam int unsigned HALF = CLK_DIV / 2;
  localparam int unsigned CW   = 8;

  logic [PW-1:0]   ph;
  logic [PW-1:0]   ph_nxt;
  logic [SW-1:0]   sel;
  logic [7:0]      slv_d;
  logic            slv_wait;
  logic [CW-1:0]   wcnt;
  logic [CW-1:0]   wcnt_inc;
  logic            to;
  logic            unused_a;
  logic [NIRQ-1:0] irq_s1;
  logic [NIRQ-1:0] irq_s2;
  logic [NIRQ-1:0] irq_prev;
  logic [NIRQ-1:0] irq_lat;
  logic [NIRQ-1:0] irq_lat_nxt;
  logic [NIRQ-1:0] irq_rise;

  // Phase counter and divided clock
  always_comb begin
    ph_nxt = (ph == PW'(CLK_DIV - 1)) ? '0 : ph + PW'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ph      <= '0;
      cpu_clk <= 1'b0;
    end else begin
      ph      <= ph_nxt;
      cpu_clk <= (ph_nxt >= PW'(HALF));
    end
  end

  assign gate     = (ph == PW'(GATE_PHASE));
  assign sel      = sram_a[SEL_LSB +: SW];
  assign unused_a = ^sram_a;

  // Window decode: out-of-range selects match no slave and read as idle bus
  always_comb begin
    s_cs     = '0;
    slv_d    = 8'hFF;
    slv_wait = 1'b0;
    for (int unsigned k = 0; k < NSLAVE; k++) begin
      if (sel == SW'(k)) begin
        s_cs[k]  = sram_cs & gate;
        slv_d    = s_d[8*k +: 8];
        slv_wait = s_wait[k];
      end
    end
  end

  assign sram_d_in = to ? 8'hFF : slv_d;
  assign sram_wait = slv_wait & ~to;
  assign wcnt_inc  = wcnt + CW'(1);

  // Wait timeout; a new timeout takes precedence over a concurrent clear
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wcnt          <= '0;
      to            <= 1'b0;
      timeout_flag  <= 1'b0;
      timeout_slave <= '0;
    end else begin
      if (timeout_clr) timeout_flag <= 1'b0;
      if (!sram_cs) begin
        wcnt <= '0;
        to   <= 1'b0;
      end else if (gate && slv_wait && !to && (wcnt != '1)) begin
        wcnt <= wcnt_inc;
        if (wcnt_inc == CW'(WAIT_TIMEOUT)) begin
          to            <= 1'b1;
          timeout_flag  <= 1'b1;
          timeout_slave <= 3'(sel);
        end
      end
    end
  end

  // Edge latch: a fresh rising edge wins over an ack in the same cycle
  always_comb begin
    irq_rise    = irq_s2 & ~irq_prev;
    irq_lat_nxt = irq_rise | (irq_lat & ~(irq_ack & {NIRQ{gate}}));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      irq_s1   <= '0;
      irq_s2   <= '0;
      irq_prev <= '0;
      irq_lat  <= '0;
      irq_out  <= '0;
    end else begin
      irq_s1   <= irq_in;
      irq_s2   <= irq_s1;
      irq_prev <= irq_s2;
      irq_lat  <= irq_lat_nxt;
      if (gate) irq_out <= (IRQ_EDGE & irq_lat_nxt) | (~IRQ_EDGE & irq_s2);
    end
  end

endmodule

// File: tb/tb_sram_bus_fabric.sv
// Directed bench for sram_bus_fabric: divider, decode, timeout, IRQ edge/level, reset mid-access.
module tb_sram_bus_fabric;

  localparam int unsigned NSLAVE = 3;
  localparam int unsigned NIRQ   = 2;

  logic                clk = 1'b0;
  logic                nrst = 1'b0;
  logic                cpu_clk, gate, sram_wait, timeout_flag;
  logic                sram_cs = 1'b0;
  logic [15:0]         sram_a = '0;
  logic [7:0]          sram_d_in;
  logic [NSLAVE-1:0]   s_cs;
  logic [8*NSLAVE-1:0] s_d = {8'hA5, 8'h5A, 8'h11};
  logic [NSLAVE-1:0]   s_wait = '0;
  logic [NIRQ-1:0]     irq_in = '0;
  logic [NIRQ-1:0]     irq_ack = '0;
  logic [NIRQ-1:0]     irq_out;
  logic [2:0]          timeout_slave;
  logic                timeout_clr = 1'b0;

  int passed = 0;
  int total  = 0;
  int tb_ph;

  sram_bus_fabric #(
    .NSLAVE(NSLAVE), .SEL_LSB(10), .CLK_DIV(4), .GATE_PHASE(0),
    .WAIT_TIMEOUT(3), .NIRQ(NIRQ), .IRQ_EDGE(2'b10)
  ) dut (
    .clk(clk), .nrst(nrst), .cpu_clk(cpu_clk), .gate(gate),
    .sram_cs(sram_cs), .sram_a(sram_a), .sram_d_in(sram_d_in), .sram_wait(sram_wait),
    .s_cs(s_cs), .s_d(s_d), .s_wait(s_wait),
    .irq_in(irq_in), .irq_ack(irq_ack), .irq_out(irq_out),
    .timeout_flag(timeout_flag), .timeout_slave(timeout_slave), .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  // Reference phase: CLK_DIV=4, restarts at 0 on reset
  always @(posedge clk or negedge nrst) begin
    if (!nrst) tb_ph <= 0;
    else       tb_ph <= (tb_ph + 1) % 4;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_gate();
    for (int i = 0; i < 4 && tb_ph != 0; i++) step();
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #12;
    total++; if (cpu_clk !== 1'b0) $display("FAIL rst_cpu_clk got %b want 0", cpu_clk); else passed++;
    total++; if (gate !== 1'b1) $display("FAIL rst_gate got %b want 1", gate); else passed++;
    total++; if (s_cs !== 3'b000) $display("FAIL rst_s_cs got %b want 000", s_cs); else passed++;
    total++; if (timeout_flag !== 1'b0) $display("FAIL rst_flag got %b want 0", timeout_flag); else passed++;
    total++; if (timeout_slave !== 3'd0) $display("FAIL rst_slave got %0d want 0", timeout_slave); else passed++;
    total++; if (irq_out !== 2'b00) $display("FAIL rst_irq_out got %b want 00", irq_out); else passed++;
    total++; if (sram_wait !== 1'b0) $display("FAIL rst_wait got %b want 0", sram_wait); else passed++;
  endtask

  task automatic test_divider();
    @(negedge clk);
    nrst = 1'b1;
    #1;
    total++; if (cpu_clk !== 1'b0) $display("FAIL div_cpu_clk0 got %b want 0", cpu_clk); else passed++;
    total++; if (gate !== 1'b1) $display("FAIL div_gate0 got %b want 1", gate); else passed++;
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (cpu_clk !== ((k % 4) >= 2)) $display("FAIL div_cpu_clk cyc %0d got %b want %b", k, cpu_clk, ((k % 4) >= 2));
      else passed++;
      total++;
      if (gate !== ((k % 4) == 0)) $display("FAIL div_gate cyc %0d got %b want %b", k, gate, ((k % 4) == 0));
      else passed++;
    end
  endtask

  task automatic test_decode();
    to_gate();
    sram_cs = 1'b1; sram_a = 16'h0800; s_wait = '0;
    #1;
    total++; if (s_cs !== 3'b100) $display("FAIL dec_cs_gate got %b want 100", s_cs); else passed++;
    total++; if (sram_d_in !== 8'hA5) $display("FAIL dec_data got %h want a5", sram_d_in); else passed++;
    total++; if (sram_wait !== 1'b0) $display("FAIL dec_wait0 got %b want 0", sram_wait); else passed++;
    step();
    s_wait = 3'b100;
    #1;
    total++; if (s_cs !== 3'b000) $display("FAIL dec_cs_nogate got %b want 000", s_cs); else passed++;
    total++; if (sram_wait !== 1'b1) $display("FAIL dec_wait1 got %b want 1", sram_wait); else passed++;
    s_wait = '0;
    to_gate();
    sram_a = 16'h0C00; s_wait = 3'b111;
    #1;
    total++; if (s_cs !== 3'b000) $display("FAIL dec_oor_cs got %b want 000", s_cs); else passed++;
    total++; if (sram_d_in !== 8'hFF) $display("FAIL dec_oor_data got %h want ff", sram_d_in); else passed++;
    total++; if (sram_wait !== 1'b0) $display("FAIL dec_oor_wait got %b want 0", sram_wait); else passed++;
    s_wait = '0; sram_a = 16'h1800;
    #1;
    total++; if (sram_d_in !== 8'hA5) $display("FAIL dec_upper_bits got %h want a5", sram_d_in); else passed++;
    sram_a = 16'h0000;
    #1;
    total++; if (s_cs !== 3'b001) $display("FAIL dec_sel0_cs got %b want 001", s_cs); else passed++;
    total++; if (sram_d_in !== 8'h11) $display("FAIL dec_sel0_data got %h want 11", sram_d_in); else passed++;
    sram_cs = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    to_gate();
    sram_cs = 1'b1; sram_a = 16'h0400; s_wait = 3'b010;
    #1;
    total++; if (sram_wait !== 1'b1) $display("FAIL to_wait_start got %b want 1", sram_wait); else passed++;
    total++; if (sram_d_in !== 8'h5A) $display("FAIL to_data_start got %h want 5a", sram_d_in); else passed++;
    for (int i = 0; i < 8; i++) step();
    total++; if (sram_wait !== 1'b1) $display("FAIL to_wait_g3 got %b want 1", sram_wait); else passed++;
    total++; if (timeout_flag !== 1'b0) $display("FAIL to_flag_early got %b want 0", timeout_flag); else passed++;
    step();
    total++; if (sram_wait !== 1'b0) $display("FAIL to_wait_rel got %b want 0", sram_wait); else passed++;
    total++; if (timeout_flag !== 1'b1) $display("FAIL to_flag got %b want 1", timeout_flag); else passed++;
    total++; if (timeout_slave !== 3'd1) $display("FAIL to_slave got %0d want 1", timeout_slave); else passed++;
    total++; if (sram_d_in !== 8'hFF) $display("FAIL to_data got %h want ff", sram_d_in); else passed++;
    step();
    sram_cs = 1'b0;
    step();
    sram_cs = 1'b1;
    #1;
    total++; if (timeout_flag !== 1'b1) $display("FAIL to_flag_sticky got %b want 1", timeout_flag); else passed++;
    total++; if (sram_wait !== 1'b1) $display("FAIL to_resel_wait1 got %b want 1", sram_wait); else passed++;
    s_wait = 3'b000;
    #1;
    total++; if (sram_wait !== 1'b0) $display("FAIL to_resel_wait0 got %b want 0", sram_wait); else passed++;
    s_wait = 3'b010;
    step();
    for (int i = 0; i < 8; i++) step();
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    total++; if (timeout_flag !== 1'b1) $display("FAIL to_clr_vs_set got %b want 1", timeout_flag); else passed++;
    total++; if (sram_wait !== 1'b0) $display("FAIL to_wait_rel2 got %b want 0", sram_wait); else passed++;
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    total++; if (timeout_flag !== 1'b0) $display("FAIL to_clr got %b want 0", timeout_flag); else passed++;
    total++; if (timeout_slave !== 3'd1) $display("FAIL to_slave_kept got %0d want 1", timeout_slave); else passed++;
  endtask

  task automatic test_reset_mid();
    sram_cs = 1'b0;
    step();
    sram_cs = 1'b1;
    to_gate();
    for (int i = 0; i < 9; i++) step();
    step();
    total++; if (timeout_flag !== 1'b1) $display("FAIL rm_flag_pre got %b want 1", timeout_flag); else passed++;
    total++; if (cpu_clk !== 1'b1) $display("FAIL rm_cpu_clk_pre got %b want 1", cpu_clk); else passed++;
    @(negedge clk);
    nrst = 1'b0;
    #1;
    total++; if (cpu_clk !== 1'b0) $display("FAIL rm_cpu_clk got %b want 0", cpu_clk); else passed++;
    total++; if (timeout_flag !== 1'b0) $display("FAIL rm_flag got %b want 0", timeout_flag); else passed++;
    total++; if (timeout_slave !== 3'd0) $display("FAIL rm_slave got %0d want 0", timeout_slave); else passed++;
    total++; if (sram_wait !== 1'b1) $display("FAIL rm_wait got %b want 1", sram_wait); else passed++;
    total++; if (sram_d_in !== 8'h5A) $display("FAIL rm_data got %h want 5a", sram_d_in); else passed++;
    #10;
    nrst = 1'b1;
    step();
    total++; if (sram_wait !== 1'b1) $display("FAIL rm_wait_after got %b want 1", sram_wait); else passed++;
    sram_cs = 1'b0; s_wait = '0;
    step();
  endtask

  task automatic test_irq_edge();
    to_gate();
    irq_in = 2'b10;
    step();
    irq_in = 2'b00;
    for (int i = 0; i < 3; i++) step();
    total++; if (irq_out[1] !== 1'b0) $display("FAIL irqe_before_gate got %b want 0", irq_out[1]); else passed++;
    step();
    total++; if (irq_out[1] !== 1'b1) $display("FAIL irqe_set got %b want 1", irq_out[1]); else passed++;
    for (int i = 0; i < 7; i++) step();
    total++; if (irq_out[1] !== 1'b1) $display("FAIL irqe_hold got %b want 1", irq_out[1]); else passed++;
    irq_ack = 2'b10;
    step();
    irq_ack = 2'b00;
    total++; if (irq_out[1] !== 1'b0) $display("FAIL irqe_ack got %b want 0", irq_out[1]); else passed++;
    step();
    irq_in = 2'b10;
    step();
    irq_in = 2'b00;
    step();
    irq_ack = 2'b10;
    step();
    irq_ack = 2'b00;
    total++; if (irq_out[1] !== 1'b1) $display("FAIL irqe_set_vs_ack got %b want 1", irq_out[1]); else passed++;
    for (int i = 0; i < 4; i++) step();
    total++; if (irq_out[1] !== 1'b1) $display("FAIL irqe_set_vs_ack_hold got %b want 1", irq_out[1]); else passed++;
    to_gate();
    irq_ack = 2'b10;
    step();
    irq_ack = 2'b00;
  endtask

  task automatic test_irq_level();
    to_gate();
    irq_in = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 10) irq_in = 2'b00;
      total++;
      if (irq_out[0] !== (k >= 5 && k < 13))
        $display("FAIL irql cyc %0d got %b want %b", k, irq_out[0], (k >= 5 && k < 13));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_decode();
    test_timeout();
    test_reset_mid();
    test_irq_edge();
    test_irq_level();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
